flp_align_pipe: RTL

- Pipelined, N-operand floating-point exponent aligner with a valid/ready handshake.
- Finds the largest exponent among NOPS operands, then right-shifts every significand by its exponent difference.
- Each aligned significand carries RSWIDTH extra low-order round bits.
- Sits in front of the multi-operand FP adder and accumulator datapath; replaces pairwise combinational alignment on the wide-reduction path.

---
 rtl/flp_pkg.sv | 28 ++
 rtl/flp_align_shr.sv | 50 +++++
 rtl/flp_align_pipe.sv | 126 ++++++++++++
 3 files changed

// File: rtl/flp_pkg.sv
// Shared floating-point helpers: FP32 field widths, the aligned-significand
// width and packed-slice index helpers used by the alignment datapath.
package flp_pkg;

    // FP32 field widths
    localparam int unsigned FP32_EWIDTH  = 8;
    localparam int unsigned FP32_SWIDTH  = 23;
    localparam int unsigned FP32_RSWIDTH = 2;

    // Width of an aligned significand: hidden bit + stored bits + round bits
    function automatic int unsigned aligned_width(input int unsigned swidth,
                                                  input int unsigned rswidth);
        return swidth + 1 + rswidth;
    endfunction

    // Low bit index of element idx in a packed vector of width-bit elements
    function automatic int unsigned slice_lo(input int unsigned idx,
                                             input int unsigned width);
        return idx * width;
    endfunction

    // High bit index of element idx in a packed vector of width-bit elements
    function automatic int unsigned slice_hi(input int unsigned idx,
                                             input int unsigned width);
        return (idx + 1) * width - 1;
    endfunction

endpackage

// File: rtl/flp_align_shr.sv
// Saturating right shifter for one significand. The input is extended with
// RSWIDTH zero round bits, then shifted right by shamt. Shift amounts at or
// beyond the extended width give zero.
// Optional feature macro: FLP_ALIGN_PIPE_STICKY_EN -- when defined, bit 0 of
// the result also collects every 1-bit shifted out (sticky bit).
module flp_align_shr #(
    parameter int unsigned SGW     = 24,
    parameter int unsigned RSWIDTH = 2,
    parameter int unsigned SHW     = 8
) (
    input  logic [SGW-1:0]         sg,
    input  logic [SHW-1:0]         shamt,
    output logic [SGW+RSWIDTH-1:0] res
);

    localparam int unsigned AW = SGW + RSWIDTH;
    // Compare width wide enough for both the shift amount and AW
    localparam int unsigned CW = (SHW > 32) ? SHW : 32;

    logic [AW-1:0] ext;
    logic [AW-1:0] shifted;
    logic [CW-1:0] shamt_w;
    logic          sat;

    assign ext     = {sg, {RSWIDTH{1'b0}}};
    assign shamt_w = CW'(shamt);
    assign sat     = (shamt_w >= CW'(AW));
    assign shifted = ext >> shamt;

`ifdef FLP_ALIGN_PIPE_STICKY_EN
    logic [AW-1:0] lost_mask;
    logic          lost;

    // Mask covers the bits that fall off the bottom; all ones when saturated
    assign lost_mask = ~({AW{1'b1}} << shamt);
    assign lost      = |(ext & lost_mask);

    // Truncating shift with the lost bits folded into bit 0
    always_comb begin
        res    = sat ? '0 : shifted;
        res[0] = res[0] | lost;
    end
`else
    // Plain truncating shift, zero when saturated
    always_comb begin
        res = sat ? '0 : shifted;
    end
`endif

endmodule

// File: rtl/flp_align_pipe.sv
// Two-stage N-operand exponent aligner with valid/ready handshake.
// S1 registers the significands, the maximum exponent and per-operand shift
// distances; S2 registers the right-shifted significands and the common
// exponent. Either stage advances whenever the stage after it can take data.
// Optional feature macro: FLP_ALIGN_PIPE_STICKY_EN (sticky bit, see
// flp_align_shr).
module flp_align_pipe
    import flp_pkg::*;
#(
    parameter int unsigned NOPS    = 4,
    parameter int unsigned EWIDTH  = FP32_EWIDTH,
    parameter int unsigned SWIDTH  = FP32_SWIDTH,
    parameter int unsigned RSWIDTH = FP32_RSWIDTH
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [NOPS*(SWIDTH+1)-1:0]         i_sg,
    input  logic [NOPS*EWIDTH-1:0]             i_ex,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [NOPS*(SWIDTH+1+RSWIDTH)-1:0] o_sg,
    output logic [EWIDTH-1:0]                  o_ex
);

    localparam int unsigned SGW   = SWIDTH + 1;
    localparam int unsigned AW    = aligned_width(SWIDTH, RSWIDTH);
    localparam int unsigned LVLS  = $clog2(NOPS);
    localparam int unsigned NLEAF = 1 << LVLS;

    // Stage state
    logic                   s1_valid;
    logic [NOPS*SGW-1:0]    s1_sg;
    logic [EWIDTH-1:0]      s1_emax;
    logic [NOPS*EWIDTH-1:0] s1_shift;
    logic                   s2_valid;

    // Handshake
    logic s1_load;
    logic s2_load;

    // Combinational datapath
    logic [EWIDTH-1:0]      emax;
    logic [NOPS*EWIDTH-1:0] shift;
    logic [NOPS*AW-1:0]     aligned;

    assign s2_load = !s2_valid || i_ready;
    assign s1_load = !s1_valid || s2_load;
    assign o_ready = s1_load;
    assign o_valid = s2_valid;

    // Max-exponent comparator tree; missing leaves are padded with zero,
    // which never wins an unsigned compare.
    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        logic [EWIDTH-1:0] node [NLEAF >> l];
        if (l == 0) begin : g_leaf
            for (genvar k = 0; k < NLEAF; k++) begin : g_op
                if (k < NOPS) begin : g_real
                    assign node[k] = i_ex[slice_lo(k, EWIDTH) +: EWIDTH];
                end else begin : g_pad
                    assign node[k] = '0;
                end
            end
        end else begin : g_cmp
            for (genvar n = 0; n < (NLEAF >> l); n++) begin : g_node
                assign node[n] = (g_lvl[l-1].node[2*n] >= g_lvl[l-1].node[2*n+1]) ?
                                 g_lvl[l-1].node[2*n] : g_lvl[l-1].node[2*n+1];
            end
        end
    end

    assign emax = g_lvl[LVLS].node[0];

    // Per-operand shift distance; never negative since emax is the maximum
    for (genvar k = 0; k < NOPS; k++) begin : g_shift
        assign shift[slice_lo(k, EWIDTH) +: EWIDTH] =
            emax - i_ex[slice_lo(k, EWIDTH) +: EWIDTH];
    end

    // S1: capture significands, max exponent and shift distances
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_valid <= 1'b0;
            s1_sg    <= '0;
            s1_emax  <= '0;
            s1_shift <= '0;
        end else if (s1_load) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_sg    <= i_sg;
                s1_emax  <= emax;
                s1_shift <= shift;
            end
        end
    end

    // One saturating shifter per operand, fed from S1
    for (genvar k = 0; k < NOPS; k++) begin : g_shr
        flp_align_shr #(
            .SGW     (SGW),
            .RSWIDTH (RSWIDTH),
            .SHW     (EWIDTH)
        ) u_shr (
            .sg    (s1_sg[slice_lo(k, SGW) +: SGW]),
            .shamt (s1_shift[slice_lo(k, EWIDTH) +: EWIDTH]),
            .res   (aligned[slice_hi(k, AW):slice_lo(k, AW)])
        );
    end

    // S2: capture aligned significands and common exponent; holds while stalled
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s2_valid <= 1'b0;
            o_sg     <= '0;
            o_ex     <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                o_sg <= aligned;
                o_ex <= s1_emax;
            end
        end
    end

endmodule
